// File: rtl/lift_pkg.sv
// Shared types for the lift call scheduler: floor numbers, FSM states and direction encoding.
// Combinational definitions only; no latency and no flow control.
package lift_pkg;
    localparam int N_FLOORS_MAX = 9;

    typedef logic [3:0] floor_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_OFFER,
        ST_WAIT_ARRIVE
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;
endpackage

// File: rtl/lift_sw_filter.sv
// One call switch: 2-flop synchroniser, plus a stable-level debounce when LIFT_SW_DEBOUNCE_EN is defined.
// Latency: 2 cycles, plus DEBOUNCE_CYCLES when debounced. The switch is free-running, so there is no backpressure.
module lift_sw_filter #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic res,
    input  logic sw_i,
    output logic filt_o
);
    logic sync0_q, sync1_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= sw_i;
            sync1_q <= sync0_q;
        end
    end

`ifdef LIFT_SW_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    // The new level is accepted only after it has differed from the current one for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync1_q == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync1_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign filt_o = filt_q;
`else
    assign filt_o = sync1_q;
`endif
endmodule

// File: rtl/lift_call_scheduler.sv
// Latches floor calls and offers one target floor at a time; tgt_valid rises 3 cycles after a call is latched.
// The offer is held stable until tgt_ready, and no new target is chosen until the car arrives. Debouncing: LIFT_SW_DEBOUNCE_EN.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS        = N_FLOORS_MAX,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                res,
    input  logic [N_FLOORS-1:0] sw,
    input  logic [3:0]          cur_floor,
    input  logic                car_idle,
    output logic                tgt_valid,
    input  logic                tgt_ready,
    output logic [3:0]          tgt_floor,
    output logic                tgt_up,
    output logic [N_FLOORS-1:0] pending
);
    localparam floor_t TOP_FLOOR = floor_t'(N_FLOORS - 1);

    logic [N_FLOORS-1:0] filt, filt_q, pending_q, pending_d, clr_mask;
    state_t              state_q;
    logic                tgt_valid_q, dir_q;
    floor_t              tgt_floor_q, cf, up_f, dn_f;
    logic                up_hit, dn_hit, arrive;

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_sw
        lift_sw_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt (
            .clk    (clk),
            .res    (res),
            .sw_i   (sw[i]),
            .filt_o (filt[i])
        );
    end

    assign cf = (cur_floor > TOP_FLOOR) ? TOP_FLOOR : cur_floor;

    // Nearest pending floor above (lowest index > cf) and below (highest index < cf).
    always_comb begin
        up_hit = 1'b0;
        up_f   = '0;
        dn_hit = 1'b0;
        dn_f   = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && floor_t'(i) > cf) begin
                up_hit = 1'b1;
                up_f   = floor_t'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i] && floor_t'(i) < cf) begin
                dn_hit = 1'b1;
                dn_f   = floor_t'(i);
            end
        end
    end

    assign arrive    = (state_q == ST_WAIT_ARRIVE) && car_idle && (cf == tgt_floor_q);
    assign clr_mask  = arrive ? (N_FLOORS'(1) << tgt_floor_q) : '0;
    // Clearing is applied after the new edges, so a simultaneous call and arrival at one floor leaves it clear.
    assign pending_d = (pending_q | (filt & ~filt_q)) & ~clr_mask;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            filt_q    <= '0;
            pending_q <= '0;
        end else begin
            filt_q    <= filt;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= ST_IDLE;
            tgt_valid_q <= 1'b0;
            tgt_floor_q <= '0;
            dir_q       <= UP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) state_q <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (pending_q[cf]) begin
                        tgt_floor_q <= cf;
                    end else if (dir_q == UP && up_hit) begin
                        tgt_floor_q <= up_f;
                    end else if (dir_q == DOWN && dn_hit) begin
                        tgt_floor_q <= dn_f;
                    end else begin
                        tgt_floor_q <= (dir_q == UP) ? dn_f : up_f;
                        dir_q       <= (dir_q == UP) ? DOWN : UP;
                    end
                    tgt_valid_q <= 1'b1;
                    state_q     <= ST_OFFER;
                end
                ST_OFFER: begin
                    if (tgt_ready) begin
                        tgt_valid_q <= 1'b0;
                        state_q     <= ST_WAIT_ARRIVE;
                    end
                end
                ST_WAIT_ARRIVE: begin
                    if (arrive) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tgt_valid = tgt_valid_q;
    assign tgt_floor = tgt_floor_q;
    assign tgt_up    = dir_q;
    assign pending   = pending_q;
endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: directed scenarios plus random call episodes scored against a floor-search model.
// Offers are pushed to a queue when predicted and popped by an independent monitor at each transfer.
module tb_lift_call_scheduler;
    localparam int NF = 9;
`ifdef LIFT_SW_DEBOUNCE_EN
    localparam int PW = 12;
`else
    localparam int PW = 2;
`endif

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic [NF-1:0] sw = '0;
    logic [3:0]    cur_floor = '0;
    logic          car_idle = 1'b0;
    logic          tgt_ready = 1'b0;
    logic          tgt_valid, tgt_up;
    logic [3:0]    tgt_floor;
    logic [NF-1:0] pending;

    lift_call_scheduler #(.N_FLOORS(NF), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .res       (res),
        .sw        (sw),
        .cur_floor (cur_floor),
        .car_idle  (car_idle),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_floor (tgt_floor),
        .tgt_up    (tgt_up),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int floor;
        bit up;
    } offer_t;

    int            n_tests = 0;
    int            n_fail = 0;
    offer_t        exp_q[$];
    logic [NF-1:0] m_pend = '0;
    bit            m_up = 1'b1;
    int            m_tgt = 0;

    task automatic check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int clampf(int f);
        return (f >= NF) ? NF - 1 : f;
    endfunction

    // Walk outward one floor at a time in the given direction; -1 when nothing is pending that way.
    function automatic int nearest(logic [NF-1:0] p, int cf, bit up);
        for (int d = 1; d < 16; d++) begin
            int f;
            f = up ? cf + d : cf - d;
            if (f >= 0 && f < NF && p[f]) return f;
        end
        return -1;
    endfunction

    task automatic predict();
        int cf, t;
        if (m_pend == '0) return;
        cf = clampf(int'(cur_floor));
        if (m_pend[cf]) t = cf;
        else begin
            t = nearest(m_pend, cf, m_up);
            if (t < 0) begin
                m_up = !m_up;
                t = nearest(m_pend, cf, m_up);
            end
        end
        m_tgt = t;
        exp_q.push_back('{t, m_up});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic call(logic [NF-1:0] mask);
        sw = mask;
        m_pend |= mask;
        repeat (PW) tick();
        sw = '0;
        repeat (PW + 4) tick();
    endtask

    // mode 0: random ready, 1: ready held low for 10 valid cycles, 2: ready always high.
    task automatic wait_xfer(int mode);
        int n, stall;
        bit x;
        n = 0;
        stall = 0;
        forever begin
            if (mode == 2) tgt_ready = 1'b1;
            else if (mode == 1) tgt_ready = (stall >= 10);
            else tgt_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            x = tgt_valid && tgt_ready;
            if (mode == 1 && tgt_valid && !tgt_ready) stall++;
            tick();
            if (x) break;
            if (++n > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer_timeout: no transfer after %0d cycles, expected one", n);
                break;
            end
        end
        tgt_ready = 1'b0;
    endtask

    task automatic serve(int mode, bit inject);
        int wf;
        wait_xfer(mode);
        car_idle = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        if (inject && $urandom_range(0, 2) == 0) call(NF'($urandom_range(1, (1 << NF) - 1)));
        if (inject && $urandom_range(0, 1) == 0) begin
            do wf = $urandom_range(0, 15); while (clampf(wf) == m_tgt);
            cur_floor = 4'(wf);
            car_idle = 1'b1;
            repeat (3) tick();
            @(negedge clk);
            check("no_clear_wrong_floor", int'(pending), int'(m_pend));
            check("tgt_held_in_wait", int'(tgt_floor), m_tgt);
            car_idle = 1'b0;
            tick();
        end
        cur_floor = 4'(m_tgt);
        car_idle = 1'b1;
        tick();
        m_pend[m_tgt] = 1'b0;
        car_idle = 1'b0;
        @(negedge clk);
        check("pending_after_arrival", int'(pending), int'(m_pend));
        predict();
    endtask

    task automatic reset_mid(bit in_wait);
        cur_floor = '0;
        call('1);
        predict();
        if (in_wait) wait_xfer(2);
        @(negedge clk);
        if (!in_wait) check("valid_before_reset", int'(tgt_valid), 1);
        #2;
        res = 1'b0;
        exp_q.delete();
        m_pend = '0;
        m_up = 1'b1;
        #1;
        check("reset_valid_async", int'(tgt_valid), 0);
        check("reset_pending_async", int'(pending), 0);
        repeat (3) tick();
        res = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("idle_after_reset_valid", int'(tgt_valid), 0);
        check("idle_after_reset_pending", int'(pending), 0);
    endtask

    // Scoreboard monitor: pops on every transfer, checks offer stability while stalled and the drop afterwards.
    initial begin
        bit     prev_stall, prev_xfer;
        int     pf;
        bit     pu;
        offer_t e;
        prev_stall = 1'b0;
        prev_xfer = 1'b0;
        forever begin
            @(negedge clk);
            if (!res) begin
                prev_stall = 1'b0;
                prev_xfer = 1'b0;
                continue;
            end
            if (prev_xfer) check("valid_drop_after_xfer", int'(tgt_valid), 0);
            if (prev_stall) begin
                check("stall_valid_held", int'(tgt_valid), 1);
                check("stall_floor_stable", int'(tgt_floor), pf);
                check("stall_dir_stable", int'(tgt_up), int'(pu));
            end
            prev_xfer = tgt_valid && tgt_ready;
            prev_stall = tgt_valid && !tgt_ready;
            pf = int'(tgt_floor);
            pu = tgt_up;
            if (prev_xfer) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL offer_unexpected: floor %0d offered, no offer expected", tgt_floor);
                end else begin
                    e = exp_q.pop_front();
                    check("offer_floor", int'(tgt_floor), e.floor);
                    check("offer_dir", int'(tgt_up), int'(e.up));
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at 5 ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pending", int'(pending), 0);
        check("reset_valid", int'(tgt_valid), 0);
        check("reset_floor", int'(tgt_floor), 0);
        check("reset_up", int'(tgt_up), 1);
        res = 1'b1;
        repeat (2) tick();

        // Single call: latency and one-cycle valid pulse with ready held high.
        cur_floor = 4'd2;
        tgt_ready = 1'b1;
        m_pend = NF'(9'h020);
        predict();
        sw[5] = 1'b1;
        repeat (PW) tick();
        sw = '0;
        k = 0;
        @(negedge clk);
        while (pending == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("first_call_latched", int'(pending), 'h020);
        check("latency_cycle1", int'(tgt_valid), 0);
        @(negedge clk);
        check("latency_cycle2", int'(tgt_valid), 0);
        @(negedge clk);
        check("latency_cycle3", int'(tgt_valid), 1);
        tick();
        tgt_ready = 1'b0;
        cur_floor = 4'd5;
        car_idle = 1'b1;
        tick();
        m_pend = '0;
        car_idle = 1'b0;
        @(negedge clk);
        check("first_call_cleared", int'(pending), 0);

        // Floors 1 and 7 from floor 4 going up: 7 first, then reverse to 1.
        cur_floor = 4'd4;
        call(NF'(9'h082));
        predict();
        serve(2, 1'b0);
        serve(2, 1'b0);

        // Long stall during the offer.
        call(NF'(9'h100));
        predict();
        serve(1, 1'b0);

`ifndef LIFT_SW_DEBOUNCE_EN
        // Call edge at floor 3 coinciding with the arrival clear at floor 3.
        call(NF'(9'h008));
        predict();
        wait_xfer(2);
        car_idle = 1'b0;
        repeat (2) tick();
        sw[3] = 1'b1;
        tick();
        tick();
        cur_floor = 4'd3;
        car_idle = 1'b1;
        tick();
        m_pend[3] = 1'b0;
        @(negedge clk);
        check("collision_clear_wins", int'(pending), 0);
        repeat (10) tick();
        @(negedge clk);
        check("held_switch_no_relatch", int'(pending), 0);
        check("held_switch_no_offer", int'(tgt_valid), 0);
        sw = '0;
        car_idle = 1'b0;
        repeat (4) tick();
`else
        // Debounce: a short glitch is rejected, a long pulse is latched.
        cur_floor = 4'd0;
        sw[0] = 1'b1;
        repeat (5) tick();
        sw = '0;
        repeat (20) tick();
        @(negedge clk);
        check("glitch_rejected", int'(pending), 0);
        call(NF'(9'h001));
        predict();
        @(negedge clk);
        check("long_pulse_latched", int'(pending), 1);
        serve(2, 1'b0);
`endif

        reset_mid(1'b0);
        reset_mid(1'b1);

        // Random episodes: out-of-range start floors, random ready, calls injected while travelling.
        repeat (25) begin
            cur_floor = 4'($urandom_range(0, 15));
            call(NF'($urandom_range(1, (1 << NF) - 1)));
            predict();
            while (m_pend != '0) serve(0, 1'b1);
        end

        repeat (10) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_call_scheduler.md
LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

Interface
REQ-001 SHALL have parameter N_FLOORS, default 9, number of served floors (0..N_FLOORS-1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable-level count required before a switch change is accepted.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port res  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sw  input  N_FLOORS  floor-call switches, asynchronous to clk.
REQ-006 SHALL have port cur_floor  input  4  floor the car is currently at, from the car controller.
REQ-007 SHALL have port car_idle  input  1  car stopped with doors open, from the car controller.
REQ-008 SHALL have port tgt_valid  output  1  a target floor is offered.
REQ-009 SHALL have port tgt_ready  input  1  the car controller accepts the target.
REQ-010 SHALL have port tgt_floor  output  4  offered target floor.
REQ-011 SHALL have port tgt_up  output  1  travel direction of the offer: 1 = up, 0 = down.
REQ-012 SHALL have port pending  output  N_FLOORS  latched calls, one bit per floor, driving the call LEDs.

Function
REQ-013 SHALL pass each sw bit through a 2-flop synchroniser before any use.
REQ-014 SHALL set pending[i] on a rising edge of the filtered sw[i]. Setting takes effect one cycle after the filtered edge. A level held high SHALL NOT re-set the bit after it clears.
REQ-015 SHALL implement FSM IDLE -> SELECT -> OFFER -> WAIT_ARRIVE -> IDLE.
REQ-016 SHALL leave IDLE when pending is non-zero, on the next clock edge.
REQ-017 In SELECT, target choice SHALL follow this priority:
  - pending[cur_floor];
  - else the nearest pending floor in the current direction;
  - else the nearest pending floor in the opposite direction, with the direction register inverted.
  The chosen floor is registered into tgt_floor and the direction register into tgt_up.
REQ-018 In OFFER, SHALL hold tgt_valid=1 and keep tgt_floor and tgt_up stable until tgt_ready=1. The transfer occurs on the cycle where both are high, and the next state is WAIT_ARRIVE.
REQ-019 tgt_valid SHALL be high only in OFFER; it deasserts the cycle after the transfer.
REQ-020 In WAIT_ARRIVE, when car_idle=1 and cur_floor==tgt_floor, SHALL clear pending[tgt_floor] and go to IDLE.
REQ-021 Calls arriving during WAIT_ARRIVE SHALL be latched but SHALL NOT re-target the car; there is no re-targeting.
REQ-022 If a call edge and a clear hit the same floor on the same cycle, the clear SHALL win.
REQ-023 Latency: with the FSM in IDLE, tgt_valid SHALL rise 3 cycles after the pending bit is set (IDLE, SELECT, OFFER).
REQ-024 cur_floor values >= N_FLOORS SHALL be treated as floor N_FLOORS-1.
REQ-025 Distance comparisons SHALL use unsigned 4-bit floor numbers. On equal distance there is no tie, since only one direction is searched at a time.

Reset
REQ-026 While res=0: FSM=IDLE, pending=0, tgt_valid=0, tgt_floor=0, tgt_up=1, synchroniser and debounce state 0.
REQ-027 Assertion of res mid-OFFER or mid-WAIT_ARRIVE SHALL drop tgt_valid immediately (asynchronous) and discard all pending calls.

Configuration
REQ-028 With LIFT_SW_DEBOUNCE_EN defined, each synchronised switch SHALL be filtered by a DEBOUNCE_CYCLES stable counter. Without it, the filtered switch SHALL be the synchroniser output directly, and DEBOUNCE_CYCLES is unused.

Structure
REQ-029 Package lift_pkg SHALL hold N_FLOORS_MAX (9), the floor_t 4-bit type, the FSM state enum, and the direction constants UP/DOWN.
REQ-030 Per-bit synchronise-plus-debounce SHALL be sub-module lift_sw_filter, instantiated N_FLOORS times.

Verification (LIFT_SW_DEBOUNCE_EN undefined unless stated)
REQ-031 Reset, then pulse sw[5] with cur_floor=2, tgt_ready=1 -> pending=9'h020, tgt_valid pulses one cycle with tgt_floor=5, tgt_up=1; then cur_floor=5, car_idle=1 -> pending=0.
REQ-032 Set pending floors 1 and 7 with cur_floor=4 and direction up -> first offer 7 (up); after arrival, offer 1 with tgt_up=0.
REQ-033 Hold tgt_ready=0 for 10 cycles during OFFER -> tgt_valid stays 1 and tgt_floor stays constant; transfer on the first tgt_ready=1 cycle.
REQ-034 sw[3] edge on the same cycle as the arrival clear at floor 3 -> pending[3]=0 afterwards. Keep sw[3] high -> no re-latch.
REQ-035 Assert res during WAIT_ARRIVE with pending=9'h1FF -> tgt_valid=0 and pending=0 with no clock edge; FSM in IDLE after release.
REQ-036 LIFT_SW_DEBOUNCE_EN defined with DEBOUNCE_CYCLES=8: a 5-cycle glitch on sw[0] -> no pending bit; a 12-cycle pulse -> pending[0] set.
